note_select: RTL and testbench

- Front-panel pitch selector that sits directly upstream of the 7-segment note display; drives its note, octave and accident inputs.
- Synchronises and debounces four raw pushbuttons: up, down, sharp, play.
- Up/down step through the 7 natural notes with octave carry and hold-to-repeat. Sharp toggles the accidental.
- Play is passed through as a debounced gate for the tone generator.

---
 rtl/note_select.sv | 160 ++++++++++++++++
 tb/tb_note_select.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_select.sv
// Front-panel pitch selector: synchronises and debounces four pushbuttons and
// steps a (note, octave, accidental) triple with hold-to-repeat on up/down.
module note_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sharp,
    input  logic       btn_play,
    output logic [2:0] note,
    output logic [1:0] octave,
    output logic       accident,
    output logic       gate,
    output logic       changed
);

    localparam int unsigned DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW     = $clog2(RPT_MX + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_RATE);

    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DOWN  = 1;
    localparam int unsigned B_SHARP = 2;
    localparam int unsigned B_PLAY  = 3;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    db;
    logic [3:0]    db_q;
    logic [DW-1:0] db_cnt [4];

    logic [RW-1:0] rpt_cnt [2];
    logic [1:0]    rpt_running;
    logic [1:0]    rpt_fire;
    logic [1:0]    step_ev;
    logic [3:0]    press;

    logic [2:0]    note_n;
    logic [1:0]    octave_n;
    logic          accident_n;

    assign btn_raw = {btn_play, btn_sharp, btn_down, btn_up};
    assign press   = db & ~db_q;

    // Two-flop synchroniser followed by a disagreement-run debouncer per button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // rpt_cnt holds cycles since the last press/repeat event; 0 means idle.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rpt_fire[i] = db[i] && (rpt_cnt[i] == (rpt_running[i] ? RPT_NEXT : RPT_FIRST));
            step_ev[i]  = press[i] | rpt_fire[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_running <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (!db[i]) begin
                    rpt_cnt[i]     <= '0;
                    rpt_running[i] <= 1'b0;
                end else if (press[i]) begin
                    rpt_cnt[i]     <= RW'(1);
                    rpt_running[i] <= 1'b0;
                end else if (rpt_fire[i]) begin
                    rpt_cnt[i]     <= RW'(1);
                    rpt_running[i] <= 1'b1;
                end else if (rpt_cnt[i] != '0) begin
                    rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                end
            end
        end
    end

    // Step first, then evaluate the sharp toggle against the stepped note.
    always_comb begin
        note_n     = note;
        octave_n   = octave;
        accident_n = accident;
        if (step_ev[B_UP] && !step_ev[B_DOWN]) begin
            if (note != 3'd6) begin
                note_n     = note + 3'd1;
                accident_n = 1'b0;
            end else if (octave != 2'd3) begin
                note_n     = '0;
                octave_n   = octave + 2'd1;
                accident_n = 1'b0;
            end
        end else if (step_ev[B_DOWN] && !step_ev[B_UP]) begin
            if (note != 3'd0) begin
                note_n     = note - 3'd1;
                accident_n = 1'b0;
            end else if (octave != 2'd0) begin
                note_n     = 3'd6;
                octave_n   = octave - 2'd1;
                accident_n = 1'b0;
            end
        end
        if (press[B_SHARP]) begin
            accident_n = (note_n == 3'd2 || note_n == 3'd6) ? 1'b0 : ~accident_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note     <= '0;
            octave   <= 2'd1;
            accident <= 1'b0;
            gate     <= 1'b0;
            changed  <= 1'b0;
        end else begin
            note     <= note_n;
            octave   <= octave_n;
            accident <= accident_n;
            gate     <= db[B_PLAY];
            changed  <= (note_n != note) || (octave_n != octave) || (accident_n != accident);
        end
    end

endmodule

// File: tb/tb_note_select.sv
// Self-checking bench for note_select: directed vector table, hand sequences for
// latency and reset-while-held, and random stimulus against a pitch-index model.
module tb_note_select;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_sharp, btn_play;
    logic [2:0] note;
    logic [1:0] octave;
    logic       accident, gate, changed;

    int total = 0;
    int bad   = 0;
    int chg_cnt;

    note_select #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_sharp(btn_sharp),
        .btn_play (btn_play),
        .note     (note),
        .octave   (octave),
        .accident (accident),
        .gate     (gate),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Reference model: pitch kept as a linear index octave*7+note in 0..27.
    int m_s1[4], m_s2[4], m_db[4], m_prev[4], m_streak[4], m_age[2];
    int m_pos, m_acc, m_gate, m_chg;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_prev[i] = 0; m_streak[i] = 0;
        end
        m_age[0] = 0; m_age[1] = 0;
        m_pos = 7; m_acc = 0; m_gate = 0; m_chg = 0;
    endtask

    task automatic model_step(input logic [3:0] raw);
        int ev[2];
        int np, na, db_new;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++)
            ev[i] = (m_db[i] != 0) && (m_age[i] == 0 || (m_age[i] >= RD && (m_age[i] - RD) % RR == 0));
        np = m_pos;
        na = m_acc;
        if (ev[0] != 0 && ev[1] == 0 && np < 27) begin np++; na = 0; end
        if (ev[1] != 0 && ev[0] == 0 && np > 0)  begin np--; na = 0; end
        if (m_db[2] != 0 && m_prev[2] == 0)
            na = (np % 7 == 2 || np % 7 == 6) ? 0 : 1 - na;
        m_chg  = (np != m_pos || na != m_acc) ? 1 : 0;
        m_pos  = np;
        m_acc  = na;
        m_gate = m_db[3];
        for (int i = 0; i < 4; i++) begin
            db_new = m_db[i];
            if (m_s2[i] != m_db[i]) begin
                m_streak[i]++;
                if (m_streak[i] == D) begin db_new = m_s2[i]; m_streak[i] = 0; end
            end else begin
                m_streak[i] = 0;
            end
            if (i < 2) m_age[i] = (db_new != 0 && m_db[i] != 0) ? m_age[i] + 1 : 0;
            m_prev[i] = m_db[i];
            m_db[i]   = db_new;
            m_s2[i]   = m_s1[i];
            m_s1[i]   = int'(raw[i]);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step({btn_play, btn_sharp, btn_down, btn_up});
        @(negedge clk);
        chk("model_note",     int'(note),     m_pos % 7);
        chk("model_octave",   int'(octave),   m_pos / 7);
        chk("model_accident", int'(accident), m_acc);
        chk("model_gate",     int'(gate),     m_gate);
        chk("model_changed",  int'(changed),  m_chg);
        if (changed) chg_cnt++;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_play, btn_sharp, btn_down, btn_up} = b;
    endtask

    typedef struct {
        string      nm;
        logic [3:0] btn;    // {play, sharp, down, up}
        int         hold;
        int         n;
        int         note;
        int         oct;
        int         acc;
        int         chg;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        set_btn(4'b0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_note",     int'(note),     0);
        chk("reset_octave",   int'(octave),   1);
        chk("reset_accident", int'(accident), 0);
        chk("reset_gate",     int'(gate),     0);
        chk("reset_changed",  int'(changed),  0);
        rst_n = 1'b1;

        // Clean press latency: raw sampled at edge 0, result at edge D+2.
        chg_cnt = 0;
        set_btn(4'b0001);
        repeat (D + 2) tick();
        chk("lat_note_before", int'(note), 0);
        tick();
        chk("lat_note_after", int'(note), 1);
        chk("lat_changed_hi", int'(changed), 1);
        tick();
        chk("lat_changed_lo", int'(changed), 0);
        set_btn(4'b0000);
        repeat (14) tick();
        chk("lat_octave", int'(octave), 1);
        chk("lat_accident", int'(accident), 0);

        vecs.push_back('{"glitch_up",     4'b0001,  3,  1, 1, 1, 0, 0});
        vecs.push_back('{"up_to_B",       4'b0001,  8,  5, 6, 1, 0, 5});
        vecs.push_back('{"carry_up",      4'b0001,  8,  1, 0, 2, 0, 1});
        vecs.push_back('{"carry_down",    4'b0001 << 1, 8, 1, 6, 1, 0, 1});
        vecs.push_back('{"up_to_top",     4'b0001,  8, 14, 6, 3, 0, 14});
        vecs.push_back('{"top_clamp",     4'b0001,  8,  1, 6, 3, 0, 0});
        vecs.push_back('{"down_to_bot",   4'b0010,  8, 27, 0, 0, 0, 27});
        vecs.push_back('{"bot_clamp",     4'b0010,  8,  1, 0, 0, 0, 0});
        vecs.push_back('{"sharp_on",      4'b0100,  8,  1, 0, 0, 1, 1});
        vecs.push_back('{"sharp_off",     4'b0100,  8,  1, 0, 0, 0, 1});
        vecs.push_back('{"up_to_E",       4'b0001,  8,  2, 2, 0, 0, 2});
        vecs.push_back('{"sharp_E",       4'b0100,  8,  1, 2, 0, 0, 0});
        vecs.push_back('{"down_to_D",     4'b0010,  8,  1, 1, 0, 0, 1});
        vecs.push_back('{"sharp_D",       4'b0100,  8,  1, 1, 0, 1, 1});
        vecs.push_back('{"step_clears",   4'b0001,  8,  1, 2, 0, 0, 1});
        vecs.push_back('{"up_down_both",  4'b0011,  8,  1, 2, 0, 0, 0});
        vecs.push_back('{"up_to_C1",      4'b0001,  8,  5, 0, 1, 0, 5});
        vecs.push_back('{"hold_repeat",   4'b0001, 40,  1, 5, 1, 0, 5});
        vecs.push_back('{"up_sharp_to_B", 4'b0101,  8,  1, 6, 1, 0, 1});
        vecs.push_back('{"up_sharp_to_C", 4'b0101,  8,  1, 0, 2, 1, 1});

        foreach (vecs[k]) begin
            chg_cnt = 0;
            for (int p = 0; p < vecs[k].n; p++) begin
                set_btn(vecs[k].btn);
                repeat (vecs[k].hold) tick();
                set_btn(4'b0000);
                repeat (14) tick();
            end
            chk({vecs[k].nm, "_note"},    int'(note),     vecs[k].note);
            chk({vecs[k].nm, "_octave"},  int'(octave),   vecs[k].oct);
            chk({vecs[k].nm, "_acc"},     int'(accident), vecs[k].acc);
            chk({vecs[k].nm, "_changes"}, chg_cnt,        vecs[k].chg);
        end

        // Play held through a reset: gate drops at once, returns D+3 edges after release.
        set_btn(4'b1000);
        repeat (D + 3) tick();
        chk("play_gate_on", int'(gate), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_gate_off", int'(gate), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_octave", int'(octave), 1);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (D + 2) tick();
        chk("rel_gate_still_off", int'(gate), 0);
        tick();
        chk("rel_gate_on", int'(gate), 1);
        set_btn(4'b0000);
        repeat (10) tick();

        // Random phase: per-button toggle probabilities give glitches and long holds.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) btn_up    = ~btn_up;
            if ($urandom_range(0, 29) == 0) btn_down  = ~btn_down;
            if ($urandom_range(0, 7)  == 0) btn_sharp = ~btn_sharp;
            if ($urandom_range(0, 7)  == 0) btn_play  = ~btn_play;
            rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
